serial_frame_rx: RTL and testbench

//  Serial-to-parallel frame receiver. Consumes the 1-bit-per-clock serial stream leaving the
//  3-bit SISO shift register (its s_out drives s_in here) and delivers one framed byte per frame.

---
 rtl/serial_frame_rx.sv | 124 ++++++++++++
 tb/tb_serial_frame_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start=1, DATA_W bits LSB first, optional parity, stop=0.
// Delivers each good frame on a one-deep valid/ready output and flags parity, framing and overrun errors.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_perr,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  // state  | meaning
  // IDLE   | line idle (0s), waiting for a start bit
  // DATA   | shifting in DATA_W data bits, LSB first
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit, delivering or discarding the frame
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_perr_q, rx_perr_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                last_bit;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perr_q   <= rx_perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (s_in) state_d = S_DATA;
      S_DATA:   if (last_bit) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    rx_data_d   = rx_data_q;
    rx_perr_d   = rx_perr_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        perr_d = 1'b0;
      end
      S_DATA: begin
        shreg_d = {s_in, shreg_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
      end
      S_PARITY: perr_d = (^{shreg_q, s_in}) ^ 1'(PARITY_ODD);
      S_STOP: begin
        // A bad stop bit discards the frame outright, so it can never also overrun.
        if (s_in) begin
          frame_err_d = 1'b1;
        end else if (!rx_valid_q || rx_ready) begin
          rx_data_d  = shreg_q;
          rx_perr_d  = (PARITY_EN != 0) ? perr_q : 1'b0;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_perr   = rx_perr_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx against a frame-level reference model.
module tb_serial_frame_rx;
  localparam int DATA_W     = 8;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;
  localparam int FL         = 2 + DATA_W + PARITY_EN;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                bad_par;
    bit                bad_stop;
    int                gap;
  } frame_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_in;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_perr;
  logic              frame_err;
  logic              overrun;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // held output word of the reference model
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  bit                m_perr;

  serial_frame_rx #(.DATA_W(DATA_W), .PARITY_EN(PARITY_EN), .PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_perr(rx_perr), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rx_valid"},  32'(rx_valid),  0);
    chk({tag, " rx_data"},   32'(rx_data),   0);
    chk({tag, " rx_perr"},   32'(rx_perr),   0);
    chk({tag, " frame_err"}, 32'(frame_err), 0);
    chk({tag, " overrun"},   32'(overrun),   0);
    chk({tag, " busy"},      32'(busy),      0);
  endtask

  // mode: 0 ready low, 1 ready high, 2 random, 3 ready high only on stop edges
  task automatic run(input frame_t fq[$], input int mode, input int tail);
    bit   bq[$];
    int   pq[$];
    int   iq[$];
    bit   pbit, rdy, acc, fe, ov, exp_perr;
    frame_t f;
    for (int i = 0; i < fq.size(); i++) begin
      f = fq[i];
      for (int g = 0; g < f.gap; g++) begin bq.push_back(0); pq.push_back(-1); iq.push_back(-1); end
      bq.push_back(1); pq.push_back(0); iq.push_back(i);
      for (int j = 0; j < DATA_W; j++) begin bq.push_back(f.data[j]); pq.push_back(1 + j); iq.push_back(i); end
      if (PARITY_EN != 0) begin
        pbit = (($countones(f.data) % 2) != PARITY_ODD) ^ f.bad_par;
        bq.push_back(pbit); pq.push_back(DATA_W + 1); iq.push_back(i);
      end
      bq.push_back(f.bad_stop); pq.push_back(FL - 1); iq.push_back(i);
    end
    for (int t = 0; t < tail; t++) begin bq.push_back(0); pq.push_back(-1); iq.push_back(-1); end

    for (int k = 0; k < bq.size(); k++) begin
      case (mode)
        0: rdy = 0;
        1: rdy = 1;
        2: rdy = ($urandom_range(0, 2) != 0);
        default: rdy = (pq[k] == FL - 1);
      endcase
      s_in     = bq[k];
      rx_ready = rdy;
      @(posedge clk);
      acc = m_valid && rdy;
      fe  = 0;
      ov  = 0;
      if (pq[k] == FL - 1 && fq[iq[k]].bad_stop) begin
        fe = 1;
        if (acc) m_valid = 0;
      end else if (pq[k] == FL - 1) begin
        f = fq[iq[k]];
        pbit = (($countones(f.data) % 2) != PARITY_ODD) ^ f.bad_par;
        exp_perr = (PARITY_EN != 0) && ((($countones(f.data) + pbit) % 2) != PARITY_ODD);
        if (!m_valid || acc) begin
          m_valid = 1; m_data = f.data; m_perr = exp_perr;
        end else begin
          ov = 1;
        end
      end else if (acc) begin
        m_valid = 0;
      end
      #1;
      chk("rx_valid", 32'(rx_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rx_data", 32'(rx_data), 32'(m_data));
        chk("rx_perr", 32'(rx_perr), 32'(m_perr));
      end
      chk("frame_err", 32'(frame_err), 32'(fe));
      chk("overrun",   32'(overrun),   32'(ov));
      chk("busy",      32'(busy),      32'(pq[k] >= 0 && pq[k] < FL - 1));
    end
  endtask

  function automatic frame_t mk(input logic [DATA_W-1:0] d, input bit bp, input bit bs, input int gap);
    frame_t f;
    f.data = d; f.bad_par = bp; f.bad_stop = bs; f.gap = gap;
    return f;
  endfunction

  initial begin
    frame_t fq[$];
    logic [DATA_W-1:0] partial;
    rst = 1; s_in = 0; rx_ready = 0;
    m_valid = 0; m_data = '0; m_perr = 0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 0;

    // reset in the middle of a frame
    partial = 8'hF3;
    s_in = 1; @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin s_in = partial[j]; @(posedge clk); #1; end
    chk("midframe busy", 32'(busy), 1);
    rst = 1; #1;
    chk_all_zero("midframe reset");
    s_in = 0;
    @(posedge clk); #1;
    chk_all_zero("held reset");
    @(negedge clk) rst = 0;
    fq = {mk(8'h5A, 0, 0, 1)}; run(fq, 1, 3);

    fq = {mk(8'hA5, 0, 0, 0)}; run(fq, 1, 3);   // good frame, latency
    fq = {mk(8'h01, 1, 0, 0)}; run(fq, 1, 3);   // parity error
    fq = {mk(8'h3C, 0, 1, 0)}; run(fq, 1, 3);   // framing error

    fq = {mk(8'h11, 0, 0, 0), mk(8'h22, 0, 0, 0)}; run(fq, 0, 2);  // overrun
    fq = {};                                       run(fq, 1, 3);  // drain

    fq = {mk(8'h66, 0, 0, 0)}; run(fq, 0, 2);   // hold 0x66
    fq = {mk(8'h77, 0, 0, 0)}; run(fq, 3, 2);   // accept and load together
    fq = {};                   run(fq, 1, 2);

    fq = {};
    for (int i = 0; i < 60; i++)
      fq.push_back(mk(DATA_W'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 2)));
    run(fq, 2, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
